// File: rtl/vga_pattern_core_if.sv
// Video bundle between the pattern core and the VGA connector.
// Control inputs (switch, mode) travel toward the core; sync, position and colour come back out.
interface vga_pattern_core_if #(
  parameter int C_BITS = 1
);
  logic [7:0]          switch;
  logic [1:0]          mode;
  logic                hsync;
  logic                vsync;
  logic                video_on;
  logic                frame_start;
  logic [10:0]         pixel_x;
  logic [10:0]         pixel_y;
  logic [3*C_BITS-1:0] rgb;

  modport master (
    input  switch, mode,
    output hsync, vsync, video_on, frame_start, pixel_x, pixel_y, rgb
  );

  modport slave (
    output switch, mode,
    input  hsync, vsync, video_on, frame_start, pixel_x, pixel_y, rgb
  );
endinterface

// File: rtl/vga_pattern_core.sv
// VGA timing plus four-mode test-pattern generator with a pixel-tick divider.
// Every output is registered on the pixel tick from the same hc/vc, so all of them describe one pixel.
module vga_pattern_core #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   C_BITS   = 1,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input logic                i_clk,
  input logic                i_rst_n,
  vga_pattern_core_if.master io_vga
);

  localparam int         DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int         RGB_W    = 3 * C_BITS;
  localparam [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam [10:0]      H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam [10:0]      V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam [10:0]      H_VIS    = 11'(H_ACTIVE);
  localparam [10:0]      V_VIS    = 11'(V_ACTIVE);
  localparam [10:0]      HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam [10:0]      HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam [10:0]      VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam [10:0]      VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam [10:0]      BAR_LAST = 11'(H_ACTIVE / 8 - 1);

  logic [DIV_W-1:0] r_div;
  logic [10:0]      r_hc;
  logic [10:0]      r_vc;
  logic [10:0]      r_bar_cnt;
  logic [2:0]       r_bar_idx;
  logic [4:0]       r_frame;
  logic [1:0]       r_mode;
  logic [7:0]       r_sw;

  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic             r_frame_start;
  logic [10:0]      r_pixel_x;
  logic [10:0]      r_pixel_y;
  logic [RGB_W-1:0] r_rgb;

  logic             w_tick;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_first;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_video;
  logic [1:0]       w_mode;
  logic [7:0]       w_sw;
  logic [3:0]       w_k;
  logic [2:0]       w_bsel;
  logic [RGB_W-1:0] w_base;
  logic [RGB_W-1:0] w_rgb;

  assign w_tick   = (r_div == DIV_LAST);
  assign w_h_wrap = (r_hc == H_LAST);
  assign w_v_wrap = (r_vc == V_LAST);
  assign w_first  = (r_hc == 11'd0) && (r_vc == 11'd0);
  assign w_hs_act = (r_hc >= HS_FIRST) && (r_hc <= HS_LAST);
  assign w_vs_act = (r_vc >= VS_FIRST) && (r_vc <= VS_LAST);
  assign w_video  = (r_hc < H_VIS) && (r_vc < V_VIS);

  // Pixel-tick divider
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= {DIV_W{1'b0}};
    end else if (w_tick) begin
      r_div <= {DIV_W{1'b0}};
    end else begin
      r_div <= r_div + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Horizontal and vertical position counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hc <= 11'd0;
      r_vc <= 11'd0;
    end else if (w_tick) begin
      if (w_h_wrap) begin
        r_hc <= 11'd0;
        r_vc <= w_v_wrap ? 11'd0 : r_vc + 11'd1;
      end else begin
        r_hc <= r_hc + 11'd1;
      end
    end
  end

  // Colour-bar position tracked by a pixel counter and bar index
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bar_cnt <= 11'd0;
      r_bar_idx <= 3'd0;
    end else if (w_tick) begin
      if (w_h_wrap) begin
        r_bar_cnt <= 11'd0;
        r_bar_idx <= 3'd0;
      end else if (r_bar_cnt == BAR_LAST) begin
        r_bar_cnt <= 11'd0;
        r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
        r_bar_cnt <= r_bar_cnt + 11'd1;
      end
    end
  end

  // Frame counter and once-per-frame control capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame <= 5'd0;
      r_mode  <= 2'd0;
      r_sw    <= 8'd0;
    end else begin
      if (w_tick && w_h_wrap && w_v_wrap) begin
        r_frame <= r_frame + 5'd1;
      end
      if (w_tick && w_first) begin
        r_mode <= io_vga.mode;
        r_sw   <= io_vga.switch;
      end
    end
  end

  // Pixel (0,0) already uses the controls being captured, so the whole frame is consistent
  always_comb begin
    w_mode = r_mode;
    w_sw   = r_sw;
    if (w_first) begin
      w_mode = io_vga.mode;
      w_sw   = io_vga.switch;
    end else begin
      w_mode = r_mode;
      w_sw   = r_sw;
    end
  end

  // Pattern colour for the current hc/vc
  always_comb begin
    w_base = {{C_BITS{w_sw[2]}}, {C_BITS{w_sw[1]}}, {C_BITS{w_sw[0]}}};
    w_k    = {1'b0, w_sw[5:3]};
    w_bsel = 3'd2 + {1'b0, w_sw[7:6]};
    w_rgb  = {RGB_W{1'b0}};
    case (w_mode)
      2'd0: w_rgb = w_base;
      2'd1: w_rgb = {{C_BITS{r_bar_idx[2]}}, {C_BITS{r_bar_idx[1]}}, {C_BITS{r_bar_idx[0]}}};
      2'd2: w_rgb = (r_hc[w_k] ^ r_vc[w_k]) ? w_base : {RGB_W{1'b0}};
      2'd3: w_rgb = r_frame[w_bsel] ? ~w_base : w_base;
      default: w_rgb = {RGB_W{1'b0}};
    endcase
  end

  // Output stage: everything sampled from the same pre-increment position
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
      r_pixel_x     <= 11'd0;
      r_pixel_y     <= 11'd0;
      r_rgb         <= {RGB_W{1'b0}};
    end else begin
      r_frame_start <= w_tick && w_first;
      if (w_tick) begin
        r_hsync    <= w_hs_act ? HS_POL : ~HS_POL;
        r_vsync    <= w_vs_act ? VS_POL : ~VS_POL;
        r_video_on <= w_video;
        r_pixel_x  <= r_hc;
        r_pixel_y  <= r_vc;
        r_rgb      <= w_video ? w_rgb : {RGB_W{1'b0}};
      end
    end
  end

  assign io_vga.hsync       = r_hsync;
  assign io_vga.vsync       = r_vsync;
  assign io_vga.video_on    = r_video_on;
  assign io_vga.frame_start = r_frame_start;
  assign io_vga.pixel_x     = r_pixel_x;
  assign io_vga.pixel_y     = r_pixel_y;
  assign io_vga.rgb         = r_rgb;

endmodule

// File: tb/tb_vga_pattern_core.sv
// Directed bench for vga_pattern_core using a shrunken raster (24x14 total, 16x10 visible).
// DUT a: CLK_DIV=2, C_BITS=1.  DUT b: CLK_DIV=1, C_BITS=4.
module tb_vga_pattern_core;
  localparam int HT = 24;
  localparam int VT = 14;
  localparam int HA = 16;
  localparam int VA = 10;
  localparam int FRAME_A = HT * VT * 2;
  localparam int FRAME_B = HT * VT;
  localparam int LIMIT = 2000;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  vga_pattern_core_if #(.C_BITS(1)) vga_a ();
  vga_pattern_core_if #(.C_BITS(4)) vga_b ();

  vga_pattern_core #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(VA), .V_FP(1), .V_SYNC(2), .V_BP(1), .C_BITS(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_a (.i_clk(clk), .i_rst_n(rst_n), .io_vga(vga_a));

  vga_pattern_core #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(VA), .V_FP(1), .V_SYNC(2), .V_BP(1), .C_BITS(4),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_b (.i_clk(clk), .i_rst_n(rst_n), .io_vga(vga_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_fs_a();
    bit ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (vga_a.frame_start) begin ok = 1'b1; break; end
    end
    if (!ok) begin vecs++; errs++; $display("FAIL wait_frame_start_a: timed out after %0d clks", LIMIT); end
  endtask

  task automatic wait_px_a(input int x, input int y);
    bit ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (vga_a.pixel_x == 11'(x) && vga_a.pixel_y == 11'(y)) begin ok = 1'b1; break; end
    end
    if (!ok) begin vecs++; errs++; $display("FAIL wait_pixel_a: (%0d,%0d) not reached", x, y); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vga_a.mode = 2'd0; vga_a.switch = 8'h00;
    vga_b.mode = 2'd0; vga_b.switch = 8'h05;
    repeat (3) @(negedge clk);
    vecs += 8;
    if (vga_a.hsync !== 1'b1) begin errs++; $display("FAIL rst_hsync: got %b want 1", vga_a.hsync); end
    if (vga_a.vsync !== 1'b1) begin errs++; $display("FAIL rst_vsync: got %b want 1", vga_a.vsync); end
    if (vga_a.video_on !== 1'b0) begin errs++; $display("FAIL rst_video_on: got %b want 0", vga_a.video_on); end
    if (vga_a.frame_start !== 1'b0) begin errs++; $display("FAIL rst_frame_start: got %b want 0", vga_a.frame_start); end
    if (vga_a.rgb !== 3'b000) begin errs++; $display("FAIL rst_rgb: got %b want 000", vga_a.rgb); end
    if (vga_a.pixel_x !== 11'd0) begin errs++; $display("FAIL rst_pixel_x: got %0d want 0", vga_a.pixel_x); end
    if (vga_a.pixel_y !== 11'd0) begin errs++; $display("FAIL rst_pixel_y: got %0d want 0", vga_a.pixel_y); end
    if (vga_b.rgb !== 12'h000) begin errs++; $display("FAIL rst_rgb_b: got %h want 000", vga_b.rgb); end
  endtask

  task automatic test_first_tick();
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (vga_a.frame_start !== 1'b0) begin errs++; $display("FAIL first_tick_early: frame_start %b want 0", vga_a.frame_start); end
    @(negedge clk);
    vecs++;
    if ({vga_a.frame_start, vga_a.video_on, vga_a.pixel_x} !== {1'b1, 1'b1, 11'd0})
      begin errs++; $display("FAIL first_tick: fs/von/x got %b/%b/%0d want 1/1/0", vga_a.frame_start, vga_a.video_on, vga_a.pixel_x); end
    @(negedge clk);
    vecs++;
    if ({vga_a.frame_start, vga_a.pixel_x} !== {1'b0, 11'd0})
      begin errs++; $display("FAIL fs_one_clk_hold: fs/x got %b/%0d want 0/0", vga_a.frame_start, vga_a.pixel_x); end
    @(negedge clk);
    vecs++;
    if (vga_a.pixel_x !== 11'd1) begin errs++; $display("FAIL second_pixel: x got %0d want 1", vga_a.pixel_x); end
  endtask

  task automatic test_timing();
    int hs_low = 0, vs_low = 0, fs_cnt = 0, fs2 = -1, hs_fall = 0;
    logic prev_hs;
    wait_fs_a();
    prev_hs = vga_a.hsync;
    for (int n = 0; n < 2 * FRAME_A; n++) begin
      if (!vga_a.hsync) hs_low++;
      if (!vga_a.vsync) vs_low++;
      if (prev_hs && !vga_a.hsync) hs_fall++;
      if (vga_a.frame_start) begin fs_cnt++; if (n > 0 && fs2 < 0) fs2 = n; end
      prev_hs = vga_a.hsync;
      @(negedge clk);
    end
    vecs += 5;
    if (hs_low != 168) begin errs++; $display("FAIL hsync_low_clks: got %0d want 168", hs_low); end
    if (vs_low != 192) begin errs++; $display("FAIL vsync_low_clks: got %0d want 192", vs_low); end
    if (hs_fall != 28) begin errs++; $display("FAIL line_count: got %0d want 28", hs_fall); end
    if (fs_cnt != 2) begin errs++; $display("FAIL frame_start_count: got %0d want 2", fs_cnt); end
    if (fs2 != FRAME_A) begin errs++; $display("FAIL frame_period: got %0d want %0d", fs2, FRAME_A); end
  endtask

  task automatic test_solid();
    vga_a.mode = 2'd0; vga_a.switch = 8'h05;
    wait_fs_a();
    for (int n = 0; n < FRAME_A; n++) begin
      int ex = (n / 2) % HT;
      int ey = (n / 2) / HT;
      logic vis = (ex < HA) && (ey < VA);
      logic [2:0] er = vis ? 3'b101 : 3'b000;
      vecs++;
      if ({vga_a.pixel_x, vga_a.pixel_y, vga_a.video_on, vga_a.rgb} !== {11'(ex), 11'(ey), vis, er})
        begin errs++; $display("FAIL solid: x/y/von/rgb got %0d/%0d/%b/%b want %0d/%0d/%b/%b", vga_a.pixel_x, vga_a.pixel_y, vga_a.video_on, vga_a.rgb, ex, ey, vis, er); end
      @(negedge clk);
    end
  endtask

  task automatic test_bars();
    vga_a.mode = 2'd1; vga_a.switch = 8'h00;
    wait_fs_a();
    for (int n = 0; n < FRAME_A; n++) begin
      int ex = (n / 2) % HT;
      int ey = (n / 2) / HT;
      logic vis = (ex < HA) && (ey < VA);
      logic [2:0] er = vis ? 3'(ex / (HA / 8)) : 3'b000;
      vecs++;
      if ({vga_a.pixel_x, vga_a.pixel_y, vga_a.rgb} !== {11'(ex), 11'(ey), er})
        begin errs++; $display("FAIL bars: x/y/rgb got %0d/%0d/%b want %0d/%0d/%b", vga_a.pixel_x, vga_a.pixel_y, vga_a.rgb, ex, ey, er); end
      @(negedge clk);
    end
  endtask

  task automatic test_checker();
    vga_a.mode = 2'd2; vga_a.switch = 8'h18;
    wait_fs_a();
    vecs++;
    if (vga_a.rgb !== 3'b000) begin errs++; $display("FAIL chk_k3_0_0: got %b want 000", vga_a.rgb); end
    wait_px_a(8, 0);
    vecs++;
    if ({vga_a.video_on, vga_a.rgb} !== 4'b1000) begin errs++; $display("FAIL chk_k3_8_0_base0: von/rgb got %b/%b want 1/000", vga_a.video_on, vga_a.rgb); end
    vga_a.switch = 8'h1F;
    wait_fs_a();
    wait_px_a(7, 0);
    vecs++;
    if (vga_a.rgb !== 3'b000) begin errs++; $display("FAIL chk_k3_7_0: got %b want 000", vga_a.rgb); end
    wait_px_a(8, 0);
    vecs++;
    if (vga_a.rgb !== 3'b111) begin errs++; $display("FAIL chk_k3_8_0: got %b want 111", vga_a.rgb); end
    wait_px_a(0, 8);
    vecs++;
    if (vga_a.rgb !== 3'b111) begin errs++; $display("FAIL chk_k3_0_8: got %b want 111", vga_a.rgb); end
    wait_px_a(8, 8);
    vecs++;
    if (vga_a.rgb !== 3'b000) begin errs++; $display("FAIL chk_k3_8_8: got %b want 000", vga_a.rgb); end
    vga_a.switch = 8'h0F;
    wait_fs_a();
    wait_px_a(1, 0);
    vecs++;
    if (vga_a.rgb !== 3'b000) begin errs++; $display("FAIL chk_k1_1_0: got %b want 000", vga_a.rgb); end
    wait_px_a(2, 0);
    vecs++;
    if (vga_a.rgb !== 3'b111) begin errs++; $display("FAIL chk_k1_2_0: got %b want 111", vga_a.rgb); end
    wait_px_a(2, 2);
    vecs++;
    if (vga_a.rgb !== 3'b000) begin errs++; $display("FAIL chk_k1_2_2: got %b want 000", vga_a.rgb); end
  endtask

  task automatic test_mode_change();
    vga_a.mode = 2'd0; vga_a.switch = 8'h05;
    wait_fs_a();
    wait_px_a(0, 5);
    vga_a.mode = 2'd1;
    wait_px_a(2, 6);
    vecs++;
    if (vga_a.rgb !== 3'b101) begin errs++; $display("FAIL modechg_same_frame_2_6: got %b want 101", vga_a.rgb); end
    wait_px_a(14, 9);
    vecs++;
    if (vga_a.rgb !== 3'b101) begin errs++; $display("FAIL modechg_same_frame_14_9: got %b want 101", vga_a.rgb); end
    wait_fs_a();
    vecs++;
    if (vga_a.rgb !== 3'b000) begin errs++; $display("FAIL modechg_new_frame_0_0: got %b want 000", vga_a.rgb); end
    wait_px_a(2, 0);
    vecs++;
    if (vga_a.rgb !== 3'b001) begin errs++; $display("FAIL modechg_bar1: got %b want 001", vga_a.rgb); end
    wait_px_a(14, 3);
    vecs++;
    if (vga_a.rgb !== 3'b111) begin errs++; $display("FAIL modechg_bar7: got %b want 111", vga_a.rgb); end
  endtask

  task automatic test_blink();
    rst_n = 1'b0;
    vga_a.mode = 2'd3; vga_a.switch = 8'h45;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 10; f++) begin
      logic [2:0] er = (f >= 8) ? 3'b010 : 3'b101;
      wait_fs_a();
      vecs++;
      if (vga_a.rgb !== er) begin errs++; $display("FAIL blink_frame%0d: got %b want %b", f, vga_a.rgb, er); end
    end
  endtask

  task automatic test_reset_midframe();
    vga_a.mode = 2'd0; vga_a.switch = 8'h05;
    wait_fs_a();
    wait_px_a(10, 4);
    vecs++;
    if (vga_a.rgb !== 3'b101) begin errs++; $display("FAIL pre_reset_rgb: got %b want 101", vga_a.rgb); end
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({vga_a.hsync, vga_a.vsync, vga_a.video_on, vga_a.frame_start, vga_a.rgb, vga_a.pixel_x, vga_a.pixel_y} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 11'd0, 11'd0})
      begin errs++; $display("FAIL async_reset: hs/vs/von/fs/rgb/x/y got %b/%b/%b/%b/%b/%0d/%0d", vga_a.hsync, vga_a.vsync, vga_a.video_on, vga_a.frame_start, vga_a.rgb, vga_a.pixel_x, vga_a.pixel_y); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vecs++;
    if ({vga_a.frame_start, vga_a.pixel_x, vga_a.pixel_y, vga_a.rgb} !== {1'b1, 11'd0, 11'd0, 3'b101})
      begin errs++; $display("FAIL restart_0_0: fs/x/y/rgb got %b/%0d/%0d/%b want 1/0/0/101", vga_a.frame_start, vga_a.pixel_x, vga_a.pixel_y, vga_a.rgb); end
  endtask

  task automatic test_wide();
    bit ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (vga_b.frame_start) begin ok = 1'b1; break; end
    end
    vecs++;
    if (!ok) begin errs++; $display("FAIL wide_frame_start: not seen in %0d clks", LIMIT); end
    for (int n = 0; n < FRAME_B; n++) begin
      int ex = n % HT;
      int ey = n / HT;
      logic vis = (ex < HA) && (ey < VA);
      logic [11:0] er = vis ? 12'hF0F : 12'h000;
      vecs++;
      if ({vga_b.pixel_x, vga_b.pixel_y, vga_b.rgb} !== {11'(ex), 11'(ey), er})
        begin errs++; $display("FAIL wide_solid: x/y/rgb got %0d/%0d/%h want %0d/%0d/%h", vga_b.pixel_x, vga_b.pixel_y, vga_b.rgb, ex, ey, er); end
      @(negedge clk);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_first_tick();
    test_timing();
    test_solid();
    test_bars();
    test_checker();
    test_mode_change();
    test_blink();
    test_reset_midframe();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/vga_pattern_core.md
Name: vga_pattern_core

Overview:
Parametrised successor to the team's VGA sync-plus-text top level. It integrates a pixel-tick divider, programmable horizontal/vertical timing counters, and a pattern generator with four switch-selectable modes. RGB output width is configurable per channel. All outputs are registered and mutually aligned. The block drives the board VGA connector directly and replaces the fixed 640x480, 3-bit path.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1)
H_ACTIVE, 640, visible pixels per line (multiple of 8)
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
C_BITS, 1, bits per colour channel
HS_POL, 0, active level of hsync
VS_POL, 0, active level of vsync

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
switch  in  8  colour/size/blink-rate control
mode  in  2  pattern select
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
video_on  out  1  high during visible area
frame_start  out  1  one-clk pulse marking output pixel (0,0)
pixel_x  out  11  column of the pixel currently on the outputs
pixel_y  out  11  line of the pixel currently on the outputs
rgb  out  3*C_BITS  {R,G,B}, each C_BITS wide

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise from the V_ parameters.
- Divider: counts 0..CLK_DIV-1. tick is asserted in the cycle the count equals CLK_DIV-1. With CLK_DIV=1, tick is high every cycle.
- Counters hc and vc update only on tick. hc wraps from H_TOTAL-1 to 0. vc increments on the hc wrap and wraps from V_TOTAL-1 to 0.
- Output stage: on each tick, every output is registered from the current (pre-increment) hc/vc. All outputs therefore describe the same pixel, one pixel period after the counter state. Outputs hold their value between ticks.
- hsync = HS_POL when H_ACTIVE+H_FP <= hc <= H_ACTIVE+H_FP+H_SYNC-1, else !HS_POL. vsync is defined the same way on vc.
- video_on = (hc < H_ACTIVE) && (vc < V_ACTIVE). rgb = 0 whenever video_on is 0.
- frame_start is high for exactly one clk: the cycle after the tick that registers (0,0).
- Control latching: mode and switch are sampled into internal registers only on the tick where hc=0 and vc=0. Changes mid-frame take effect at the next frame.
- Base colour: R = {C_BITS{sw[2]}}, G = {C_BITS{sw[1]}}, B = {C_BITS{sw[0]}}, where sw is the latched switch value.
- Mode 0, solid: every visible pixel is the base colour.
- Mode 1, colour bars:
  - bar width W = H_ACTIVE/8.
  - A bar-pixel counter and a 3-bit bar index both reset to 0 at hc=0.
  - The index increments each time the bar-pixel counter reaches W-1.
  - Colour channels are R = idx[2], G = idx[1], B = idx[0], each replicated to C_BITS.
  - No divider or multiplier is used.
- Mode 2, checkerboard: k = sw[5:3]. A pixel is the base colour if hc[k]^vc[k]=1, else black. Cell size is 2^k pixels.
- Mode 3, blink:
  - A 5-bit frame counter increments at each frame wrap.
  - Output alternates between the base colour and its bitwise complement.
  - The alternation toggles each time the frame counter bit selected by sw[7:6] (bits 2..5) toggles, i.e. every 4/8/16/32 frames.
- Reset (asserted low, asynchronous):
  - divider, hc, vc, bar and frame counters go to 0.
  - latched mode and switch go to 0.
  - hsync = !HS_POL, vsync = !VS_POL.
  - video_on, frame_start, rgb, pixel_x, pixel_y go to 0.
  - Reset asserted mid-frame restarts timing at (0,0).
  - The first tick occurs CLK_DIV clks after release.
- Arithmetic: all comparisons are unsigned on 11 bits, so the parameters support a total of up to 2047.

Test Plan:
- Defaults, reset released, run 2 frames -> hsync low for exactly 384 clks per line; line period 3200 clks; vsync low 2 lines (6400 clks); frame period 1,680,000 clks; frame_start pulses once per frame.
- mode=0, switch=8'h05 -> every visible pixel rgb=3'b101; rgb=0 for pixel_x>=640 or pixel_y>=480.
- mode=1 -> rgb=000 for x 0..79, 001 for 80..159, ..., 111 for 560..639, on every line.
- mode=2, switch=8'h18 (k=3) -> (x=0,y=0) black; (8,0) base colour 000 (switch[2:0]=0); repeat with switch=8'h1F -> (8,0)=111, (8,8)=000.
- Change mode from 0 to 1 mid-frame (y=200) -> rgb unchanged until the next frame_start, then bars appear.
- Reset pulsed low at x=300,y=100 -> outputs return to reset values immediately; after release, pixel (0,0) is registered on the first tick; C_BITS=4, CLK_DIV=1 build repeats the mode 0 check with rgb=12'hF0F.
